// File: rtl/tpu_bridge_ctl.sv
// tpu_bridge_ctl: registered bridge between the UART controller and mlp_top.
//   - ctrl_* weight/activation signals are forwarded to mlp_* with one cycle of latency.
//   - Activation/normalisation constants come from a shadow/active register file.
//     The active copy only changes while the MLP reports idle.
//   - Start requests are gated on weights-ready and on the MLP being idle.
//   - The NUM_COLS accumulators are captured when the MLP reports done.
// Optional feature: define TPU_BRIDGE_CTL_READBACK_EN to build the registered cfg_rdata readback mux.
//   Without it, cfg_rdata is tied to 0.
//
// Result handshake: result_valid rises the cycle after the MLP reports DONE_STATE and stays high with result_acc
// stable until ctrl_result_ack is sampled high while result_valid is high. result_valid drops on the following
// cycle. An ack outside that window, including in the capture cycle itself, is ignored.
module tpu_bridge_ctl #(
    parameter int NUM_COLS   = 2,
    parameter int DATA_W     = 8,
    parameter int ACT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int IDLE_STATE = 0,
    parameter int DONE_STATE = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_COLS-1:0]       ctrl_wf_push,
    input  logic [DATA_W-1:0]         ctrl_wf_data_in,
    input  logic                      ctrl_wf_reset,
    input  logic                      ctrl_init_act_valid,
    input  logic [ACT_W-1:0]          ctrl_init_act_data,
    input  logic                      ctrl_weights_ready,
    input  logic                      ctrl_start_req,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [31:0]               cfg_wdata,
    input  logic                      cfg_commit,
    output logic [31:0]               cfg_rdata,
    input  logic                      ctrl_result_ack,
    output logic                      result_valid,
    output logic [NUM_COLS*ACC_W-1:0] result_acc,
    output logic                      busy,
    output logic                      err_push,
    output logic [NUM_COLS-1:0]       mlp_wf_push,
    output logic [DATA_W-1:0]         mlp_wf_data_in,
    output logic                      mlp_wf_reset,
    output logic                      mlp_init_act_valid,
    output logic [ACT_W-1:0]          mlp_init_act_data,
    output logic                      mlp_weights_ready,
    output logic                      mlp_start_mlp,
    output logic [2:0]                mlp_vpu_activation_type,
    output logic signed [15:0]        mlp_norm_gain,
    output logic signed [31:0]        mlp_norm_bias,
    output logic [4:0]                mlp_norm_shift,
    output logic signed [15:0]        mlp_q_inv_scale,
    output logic signed [7:0]         mlp_q_zero_point,
    input  logic [3:0]                mlp_state_in,
    input  logic [NUM_COLS*ACC_W-1:0] mlp_acc_in,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COMMIT = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]         vtype;
        logic signed [15:0] gain;
        logic signed [31:0] bias;
        logic [4:0]         shift;
        logic signed [15:0] inv_scale;
        logic signed [7:0]  zp;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        vtype:     3'b001,
        gain:      16'sd256,
        bias:      32'sd0,
        shift:     5'd8,
        inv_scale: 16'sd256,
        zp:        8'sd0
    };

    localparam logic [3:0] ST_IDLE = 4'(IDLE_STATE);
    localparam logic [3:0] ST_DONE = 4'(DONE_STATE);

    state_t state, state_n;

    // Three config copies:
    //   shd - written by cfg_we.
    //   stg - the shadow as it stood when the last commit pulse arrived.
    //   act - drives the MLP.
    cfg_t shd, stg, act;

    logic commit_pend, start_pend;
    logic go_commit, go_start;
    logic capture, release_res;
    logic mlp_idle;
    logic multi_hot;

    assign mlp_idle  = (mlp_state_in == ST_IDLE);
    assign multi_hot = |(ctrl_wf_push & (ctrl_wf_push - NUM_COLS'(1)));

    // Registered passthrough. A multi-hot push is suppressed and recorded in the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mlp_wf_push        <= '0;
            mlp_wf_data_in     <= '0;
            mlp_wf_reset       <= 1'b0;
            mlp_init_act_valid <= 1'b0;
            mlp_init_act_data  <= '0;
            mlp_weights_ready  <= 1'b0;
            err_push           <= 1'b0;
        end else begin
            mlp_wf_push        <= multi_hot ? '0 : ctrl_wf_push;
            mlp_wf_data_in     <= ctrl_wf_data_in;
            mlp_wf_reset       <= ctrl_wf_reset;
            mlp_init_act_valid <= ctrl_init_act_valid;
            mlp_init_act_data  <= ctrl_init_act_data;
            mlp_weights_ready  <= ctrl_weights_ready;
            if (multi_hot)
                err_push <= 1'b1;
        end
    end

    // Shadow register writes. Each field takes the LSBs of cfg_wdata; addresses 6 and 7 are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd <= CFG_RESET;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    shd.vtype     <= cfg_wdata[2:0];
                3'd1:    shd.gain      <= cfg_wdata[15:0];
                3'd2:    shd.bias      <= cfg_wdata;
                3'd3:    shd.shift     <= cfg_wdata[4:0];
                3'd4:    shd.inv_scale <= cfg_wdata[15:0];
                3'd5:    shd.zp        <= cfg_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Snapshot the pre-write shadow on every commit pulse.
    // A write in the same cycle lands in the shadow only, and a later merged pulse refreshes the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stg <= CFG_RESET;
        else if (cfg_commit)
            stg <= shd;
    end

    // Active config only moves in COMMIT, which is entered only while the MLP is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            act <= CFG_RESET;
        else if (state == S_COMMIT)
            act <= stg;
    end

    // One-deep pending flags. They are cleared when the FSM picks the request up, and repeat pulses merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend <= 1'b0;
            start_pend  <= 1'b0;
        end else begin
            commit_pend <= go_commit ? 1'b0 : (commit_pend | cfg_commit);
            start_pend  <= go_start  ? 1'b0 : (start_pend | ctrl_start_req);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // FSM next state. A pending commit takes priority over a pending start.
    always_comb begin
        state_n     = state;
        go_commit   = 1'b0;
        go_start    = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            S_IDLE: begin
                if (commit_pend && mlp_idle) begin
                    go_commit = 1'b1;
                    state_n   = S_COMMIT;
                end else if (start_pend && ctrl_weights_ready && mlp_idle) begin
                    go_start = 1'b1;
                    state_n  = S_START;
                end
            end
            S_COMMIT: state_n = S_IDLE;
            S_START:  state_n = S_RUN;
            S_RUN: begin
                if (mlp_state_in == ST_DONE) begin
                    capture = 1'b1;
                    state_n = S_RESULT;
                end
            end
            S_RESULT: begin
                if (ctrl_result_ack) begin
                    release_res = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Start pulse is registered so it lasts exactly the one cycle spent in START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mlp_start_mlp <= 1'b0;
        else
            mlp_start_mlp <= (state == S_START);
    end

    // Result capture on DONE and release on an acknowledged result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            result_acc   <= '0;
        end else if (capture) begin
            result_valid <= 1'b1;
            result_acc   <= mlp_acc_in;
        end else if (release_res) begin
            result_valid <= 1'b0;
        end
    end

`ifdef TPU_BRIDGE_CTL_READBACK_EN
    logic [31:0] rdata_q;

    // Registered readback of the active register file, zero-extended per field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            case (cfg_addr)
                3'd0:    rdata_q <= {29'b0, act.vtype};
                3'd1:    rdata_q <= {16'b0, act.gain};
                3'd2:    rdata_q <= act.bias;
                3'd3:    rdata_q <= {27'b0, act.shift};
                3'd4:    rdata_q <= {16'b0, act.inv_scale};
                3'd5:    rdata_q <= {24'b0, act.zp};
                default: rdata_q <= '0;
            endcase
        end
    end

    assign cfg_rdata = rdata_q;
`else
    logic unused_cfg_addr;
    assign unused_cfg_addr = ^cfg_addr;
    assign cfg_rdata       = '0;
`endif

    assign busy                    = start_pend | (state == S_START) | (state == S_RUN);
    assign dbg_state               = state;
    assign mlp_vpu_activation_type = act.vtype;
    assign mlp_norm_gain           = act.gain;
    assign mlp_norm_bias           = act.bias;
    assign mlp_norm_shift          = act.shift;
    assign mlp_q_inv_scale         = act.inv_scale;
    assign mlp_q_zero_point        = act.zp;

endmodule

// File: tb/tb_tpu_bridge_ctl.sv
// Bench for tpu_bridge_ctl.
// Directed stimulus with hand-computed expectations. Start pulses and captured results are also checked by
// negedge monitors against expected queues filled by the stimulus.
module tb_tpu_bridge_ctl;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int CW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    ctrl_wf_push;
  logic [DW-1:0]    ctrl_wf_data_in;
  logic             ctrl_wf_reset;
  logic             ctrl_init_act_valid;
  logic [AW-1:0]    ctrl_init_act_data;
  logic             ctrl_weights_ready;
  logic             ctrl_start_req;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic             cfg_commit;
  logic [31:0]      cfg_rdata;
  logic             ctrl_result_ack;
  logic             result_valid;
  logic [NC*CW-1:0] result_acc;
  logic             busy;
  logic             err_push;
  logic [NC-1:0]    mlp_wf_push;
  logic [DW-1:0]    mlp_wf_data_in;
  logic             mlp_wf_reset;
  logic             mlp_init_act_valid;
  logic [AW-1:0]    mlp_init_act_data;
  logic             mlp_weights_ready;
  logic             mlp_start_mlp;
  logic [2:0]       mlp_vpu_activation_type;
  logic signed [15:0] mlp_norm_gain;
  logic signed [31:0] mlp_norm_bias;
  logic [4:0]       mlp_norm_shift;
  logic signed [15:0] mlp_q_inv_scale;
  logic signed [7:0]  mlp_q_zero_point;
  logic [3:0]       mlp_state_in;
  logic [NC*CW-1:0] mlp_acc_in;
  logic [2:0]       dbg_state;

  tpu_bridge_ctl dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_wf_push(ctrl_wf_push), .ctrl_wf_data_in(ctrl_wf_data_in), .ctrl_wf_reset(ctrl_wf_reset),
    .ctrl_init_act_valid(ctrl_init_act_valid), .ctrl_init_act_data(ctrl_init_act_data),
    .ctrl_weights_ready(ctrl_weights_ready), .ctrl_start_req(ctrl_start_req),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_rdata(cfg_rdata), .ctrl_result_ack(ctrl_result_ack), .result_valid(result_valid),
    .result_acc(result_acc), .busy(busy), .err_push(err_push),
    .mlp_wf_push(mlp_wf_push), .mlp_wf_data_in(mlp_wf_data_in), .mlp_wf_reset(mlp_wf_reset),
    .mlp_init_act_valid(mlp_init_act_valid), .mlp_init_act_data(mlp_init_act_data),
    .mlp_weights_ready(mlp_weights_ready), .mlp_start_mlp(mlp_start_mlp),
    .mlp_vpu_activation_type(mlp_vpu_activation_type), .mlp_norm_gain(mlp_norm_gain),
    .mlp_norm_bias(mlp_norm_bias), .mlp_norm_shift(mlp_norm_shift),
    .mlp_q_inv_scale(mlp_q_inv_scale), .mlp_q_zero_point(mlp_q_zero_point),
    .mlp_state_in(mlp_state_in), .mlp_acc_in(mlp_acc_in), .dbg_state(dbg_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [NC*CW-1:0] exp_q[$];
  logic [15:0]      start_exp_q[$];

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act_v, exp_v, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // monitor: start pulses must be single-cycle and carry the expected active gain
  logic st_prev = 1'b0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mlp_start_mlp) begin
        if (st_prev) begin
          checks++; failures++;
          $display("FAIL start_width actual=2+ cycles expected=1 @%0t", $time);
        end else if (start_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL start_unexpected actual=pulse expected=none @%0t", $time);
        end else begin
          chk("start_gain", mlp_norm_gain, start_exp_q.pop_front());
        end
      end
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL result_unexpected actual=0x%0h expected=none @%0t", result_acc, $time);
        end else begin
          chk("result_acc", result_acc, exp_q.pop_front());
        end
      end
    end
    st_prev = mlp_start_mlp;
    rv_prev = result_valid;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ctrl_wf_push = '0; ctrl_wf_data_in = '0; ctrl_wf_reset = 1'b0;
    ctrl_init_act_valid = 1'b0; ctrl_init_act_data = '0;
    ctrl_weights_ready = 1'b0; ctrl_start_req = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    ctrl_result_ack = 1'b0; mlp_state_in = 4'd0; mlp_acc_in = '0;
    repeat (2) step();

    // reset state
    chk("rst_type", mlp_vpu_activation_type, 1);
    chk("rst_gain", mlp_norm_gain, 256);
    chk("rst_bias", mlp_norm_bias, 0);
    chk("rst_shift", mlp_norm_shift, 8);
    chk("rst_inv_scale", mlp_q_inv_scale, 256);
    chk("rst_zp", mlp_q_zero_point, 0);
    chk("rst_start", mlp_start_mlp, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_acc", result_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_push", err_push, 0);
    chk("rst_wf_push", mlp_wf_push, 0);
    chk("rst_act_valid", mlp_init_act_valid, 0);
    chk("rst_rdata", cfg_rdata, 0);
    rst_n = 1'b1;
    step();

    // commit while idle: gain moves exactly two cycles after the commit pulse
    cfg_write(3'd1, 32'd128);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    chk("commit_t0_gain", mlp_norm_gain, 256);
    step(); chk("commit_t1_gain", mlp_norm_gain, 256);
    step(); chk("commit_t2_gain", mlp_norm_gain, 128);
    cfg_write(3'd1, 32'd64);
    repeat (4) step();
    chk("shadow_only_gain", mlp_norm_gain, 128);

    // passthrough, one-cycle latency
    ctrl_wf_push = 2'b01; ctrl_wf_data_in = 8'hA5; ctrl_init_act_valid = 1'b1;
    ctrl_init_act_data = 16'h1234; ctrl_wf_reset = 1'b1;
    step();
    chk("pt_wf_push", mlp_wf_push, 2'b01);
    chk("pt_wf_data", mlp_wf_data_in, 8'hA5);
    chk("pt_act_valid", mlp_init_act_valid, 1);
    chk("pt_act_data", mlp_init_act_data, 16'h1234);
    chk("pt_wf_reset", mlp_wf_reset, 1);
    chk("pt_err_clear", err_push, 0);
    ctrl_wf_push = 2'b11; ctrl_init_act_valid = 1'b0; ctrl_wf_reset = 1'b0;
    step();
    chk("multihot_push", mlp_wf_push, 0);
    chk("multihot_err", err_push, 1);
    chk("pt_act_valid_low", mlp_init_act_valid, 0);
    ctrl_wf_push = 2'b10;
    step();
    chk("pt_wf_push_col1", mlp_wf_push, 2'b10);
    chk("err_sticky", err_push, 1);
    ctrl_wf_push = '0;
    step();

    // readback
    cfg_addr = 3'd3; step();
`ifdef TPU_BRIDGE_CTL_READBACK_EN
    chk("rd_shift", cfg_rdata, 8);
`else
    chk("rd_off_shift", cfg_rdata, 0);
`endif
    cfg_addr = 3'd1; step();
`ifdef TPU_BRIDGE_CTL_READBACK_EN
    chk("rd_gain", cfg_rdata, 128);
`else
    chk("rd_off_gain", cfg_rdata, 0);
`endif
    cfg_addr = 3'd6; step();
    chk("rd_addr6", cfg_rdata, 0);

    // start with weights ready: pulse two cycles after the request
    ctrl_weights_ready = 1'b1;
    ctrl_start_req = 1'b1; start_exp_q.push_back(16'd128);
    step(); ctrl_start_req = 1'b0;
    chk("start_t0", mlp_start_mlp, 0);
    chk("busy_pend", busy, 1);
    chk("pt_weights_ready", mlp_weights_ready, 1);
    step(); chk("start_t1", mlp_start_mlp, 0);
    step(); chk("start_t2", mlp_start_mlp, 1);
    step(); chk("start_t3", mlp_start_mlp, 0);
    chk("busy_run", busy, 1);
    mlp_state_in = 4'd1;
    step();

    // done: capture {70000, -5}; ack in the capture cycle is ignored
    mlp_acc_in = {32'd70000, 32'hFFFF_FFFB};
    mlp_state_in = 4'd9; ctrl_result_ack = 1'b1;
    exp_q.push_back({32'd70000, 32'hFFFF_FFFB});
    step();
    ctrl_result_ack = 1'b0; mlp_state_in = 4'd0;
    chk("rv_set", result_valid, 1);
    chk("acc_captured", result_acc, {32'd70000, 32'hFFFF_FFFB});
    chk("busy_result", busy, 0);
    mlp_acc_in = '0;
    step();
    chk("rv_hold_after_early_ack", result_valid, 1);
    chk("acc_hold", result_acc, {32'd70000, 32'hFFFF_FFFB});
    ctrl_result_ack = 1'b1; step(); ctrl_result_ack = 1'b0;
    chk("rv_cleared", result_valid, 0);

    // start held while weights not ready
    ctrl_weights_ready = 1'b0;
    ctrl_start_req = 1'b1; start_exp_q.push_back(16'd128);
    step(); ctrl_start_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_held", mlp_start_mlp, 0);
    end
    chk("busy_held", busy, 1);
    ctrl_weights_ready = 1'b1;
    step(); chk("start_wr_t0", mlp_start_mlp, 0);
    step(); chk("start_wr_t1", mlp_start_mlp, 1);
    mlp_state_in = 4'd1;
    step();

    // commit during run stays pending until the FSM is back in IDLE
    cfg_write(3'd1, 32'd200);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gain_during_run", mlp_norm_gain, 128);
    end
    mlp_acc_in = {32'h8000_0000, 32'hFFFF_FFFF};
    mlp_state_in = 4'd9;
    exp_q.push_back({32'h8000_0000, 32'hFFFF_FFFF});
    step(); mlp_state_in = 4'd0;
    chk("rv_set2", result_valid, 1);
    step(); chk("gain_in_result", mlp_norm_gain, 128);
    ctrl_result_ack = 1'b1; step(); ctrl_result_ack = 1'b0;
    chk("gain_ack_t0", mlp_norm_gain, 128);
    step(); chk("gain_ack_t1", mlp_norm_gain, 128);
    step(); chk("gain_ack_t2", mlp_norm_gain, 200);

    // commit + start + write in one cycle: pre-write shadow (50) applied before the start pulse
    cfg_write(3'd1, 32'd50);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'd77;
    cfg_commit = 1'b1; ctrl_start_req = 1'b1; start_exp_q.push_back(16'd50);
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0; ctrl_start_req = 1'b0;
    chk("cs_t0_gain", mlp_norm_gain, 200);
    chk("cs_t0_start", mlp_start_mlp, 0);
    step(); chk("cs_t1_start", mlp_start_mlp, 0);
    step(); chk("cs_t2_gain", mlp_norm_gain, 50);
    chk("cs_t2_start", mlp_start_mlp, 0);
    step(); chk("cs_t3_start", mlp_start_mlp, 0);
    step(); chk("cs_t4_start", mlp_start_mlp, 1);
    mlp_state_in = 4'd1;
    step();
    mlp_acc_in = {32'd1, 32'd2}; mlp_state_in = 4'd9;
    exp_q.push_back({32'd1, 32'd2});
    step(); mlp_state_in = 4'd0;
    ctrl_result_ack = 1'b1; step(); ctrl_result_ack = 1'b0;
    chk("rv_cleared3", result_valid, 0);

    // the same-cycle write landed in the shadow; a later commit applies it
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    step(); step();
    chk("late_write_gain", mlp_norm_gain, 77);

    // every field, LSB truncation, ignored address
    cfg_write(3'd0, 32'hFFFF_FFF2);
    cfg_write(3'd2, 32'h1234_5678);
    cfg_write(3'd3, 32'h0000_003F);
    cfg_write(3'd4, 32'd512);
    cfg_write(3'd5, 32'h0000_017F);
    cfg_write(3'd6, 32'hDEAD_BEEF);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    step(); step();
    chk("fld_type", mlp_vpu_activation_type, 3'b010);
    chk("fld_bias", mlp_norm_bias, 32'h1234_5678);
    chk("fld_shift", mlp_norm_shift, 5'd31);
    chk("fld_inv_scale", mlp_q_inv_scale, 512);
    chk("fld_zp", mlp_q_zero_point, 8'h7F);
    chk("fld_gain_kept", mlp_norm_gain, 77);
    cfg_addr = 3'd0; step();
`ifdef TPU_BRIDGE_CTL_READBACK_EN
    chk("rd_type", cfg_rdata, 2);
`else
    chk("rd_off_type", cfg_rdata, 0);
`endif

    // async reset mid-run
    ctrl_start_req = 1'b1; start_exp_q.push_back(16'd77);
    step(); ctrl_start_req = 1'b0;
    step(); step();
    mlp_state_in = 4'd1;
    step();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_gain", mlp_norm_gain, 256);
    chk("arst_type", mlp_vpu_activation_type, 1);
    chk("arst_shift", mlp_norm_shift, 8);
    chk("arst_err", err_push, 0);
    chk("arst_weights_ready", mlp_weights_ready, 0);
    mlp_state_in = 4'd0;
    step(); rst_n = 1'b1; step();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("start_q_drained", start_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
